// File: rtl/sqrt_iter_unit.sv
// Restoring digit-by-digit integer square root, one root bit per cycle, go/done handshake.
// Define SQRT_REM_EN to add the registered remainder output rem.
module sqrt_iter_unit #(
    parameter int WIDTH = 16,
    localparam int N = WIDTH / 2,
    localparam int CW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             go,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     root
`ifdef SQRT_REM_EN
,   output logic [N:0]       rem
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] rad;
    logic [N+1:0]     acc;
    logic [N-1:0]     proot;
    logic [CW-1:0]    cnt;

    logic [N+3:0]     t;
    logic             ge;
    logic [N+1:0]     acc_nxt;
    logic [N-1:0]     proot_nxt;

    // Full-width compare; the subtraction only needs N+2 bits since the
    // difference is bounded by 2*root when the trial succeeds.
    always_comb begin
        t         = {acc, rad[WIDTH-1:WIDTH-2]};
        ge        = (t >= {2'b00, proot, 2'b01});
        acc_nxt   = ge ? (t[N+1:0] - {proot, 2'b01}) : t[N+1:0];
        proot_nxt = {proot[N-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rad   <= '0;
            acc   <= '0;
            proot <= '0;
            cnt   <= '0;
            root  <= '0;
`ifdef SQRT_REM_EN
            rem   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        rad   <= din;
                        acc   <= '0;
                        proot <= '0;
                        cnt   <= CW'(N);
                    end
                end
                CALC: begin
                    acc   <= acc_nxt;
                    proot <= proot_nxt;
                    rad   <= {rad[WIDTH-3:0], 2'b00};
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        root <= proot_nxt;
`ifdef SQRT_REM_EN
                        rem  <= acc_nxt[N:0];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Directed and swept checks of sqrt_iter_unit at WIDTH=16 and WIDTH=8.
module tb_sqrt_iter_unit;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        go16, go8;
    logic [15:0] din16;
    logic [7:0]  din8;
    logic        busy16, done16, busy8, done8;
    logic [7:0]  root16;
    logic [3:0]  root8;
`ifdef SQRT_REM_EN
    logic [8:0]  rem16;
    logic [4:0]  rem8;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sqrt_iter_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .clr_n(clr_n), .go(go16), .din(din16),
        .busy(busy16), .done(done16), .root(root16)
`ifdef SQRT_REM_EN
        , .rem(rem16)
`endif
    );

    sqrt_iter_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .clr_n(clr_n), .go(go8), .din(din8),
        .busy(busy8), .done(done8), .root(root8)
`ifdef SQRT_REM_EN
        , .rem(rem8)
`endif
    );

    function automatic longint isqrt(input longint d);
        longint r = 0;
        while ((r + 1) * (r + 1) <= d) r++;
        return r;
    endfunction

    // Accepts at the next edge from an IDLE cycle; lat counts falling edges until done.
    task automatic do_op16(input logic [15:0] d, output int lat, output logic b1);
        @(negedge clk);
        go16 = 1'b1;
        din16 = d;
        @(negedge clk);
        go16 = 1'b0;
        din16 = 16'($urandom);
        b1 = busy16;
        lat = 1;
        while (!done16 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (!done16) begin
            bad++;
            $display("FAIL done16_timeout din=%0d lat=%0d", d, lat);
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0; go16 = 1'b0; go8 = 1'b0; din16 = '0; din8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy16, done16, root16} !== 10'd0) begin
            bad++;
            $display("FAIL reset16 busy=%b done=%b root=%0d want 0/0/0", busy16, done16, root16);
        end
        total++;
        if ({busy8, done8, root8} !== 6'd0) begin
            bad++;
            $display("FAIL reset8 busy=%b done=%b root=%0d want 0/0/0", busy8, done8, root8);
        end
`ifdef SQRT_REM_EN
        total++;
        if (rem16 !== 9'd0 || rem8 !== 5'd0) begin
            bad++;
            $display("FAIL reset_rem rem16=%0d rem8=%0d want 0", rem16, rem8);
        end
`endif
        clr_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        logic b1;
        do_op16(16'd200, lat, b1);
        total++;
        if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", b1); end
        total++;
        if (lat != 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", lat); end
        total++;
        if (root16 !== 8'd14) begin bad++; $display("FAIL basic_root got=%0d want=14", root16); end
`ifdef SQRT_REM_EN
        total++;
        if (rem16 !== 9'd4) begin bad++; $display("FAIL basic_rem got=%0d want=4", rem16); end
`endif
        @(negedge clk);
        total++;
        if (done16 !== 1'b0 || busy16 !== 1'b0) begin
            bad++;
            $display("FAIL basic_after_done done=%b busy=%b want 0/0", done16, busy16);
        end
        total++;
        if (root16 !== 8'd14) begin bad++; $display("FAIL basic_root_hold got=%0d want=14", root16); end
    endtask

    task automatic test_boundaries();
        logic [15:0] dv [3] = '{16'd0, 16'hFFFF, 16'd65025};
        logic [7:0]  rv [3] = '{8'd0, 8'd255, 8'd255};
        logic [8:0]  mv [3] = '{9'd0, 9'd510, 9'd0};
        int lat;
        logic b1;
        for (int i = 0; i < 3; i++) begin
            do_op16(dv[i], lat, b1);
            total++;
            if (root16 !== rv[i]) begin
                bad++;
                $display("FAIL bound_root din=%0d got=%0d want=%0d", dv[i], root16, rv[i]);
            end
`ifdef SQRT_REM_EN
            total++;
            if (rem16 !== mv[i]) begin
                bad++;
                $display("FAIL bound_rem din=%0d got=%0d want=%0d", dv[i], rem16, mv[i]);
            end
`else
            if (mv[i] == 9'd1) $display("unreachable");
`endif
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int t1 = 0, t2 = 0;
        @(negedge clk);
        @(negedge clk);
        go16 = 1'b1;
        din16 = 16'd144;
        @(negedge clk);
        din16 = 16'd50;
        k = 1;
        while (t2 == 0 && k < 60) begin
            if (done16) begin
                if (t1 == 0) begin
                    t1 = k;
                    total++;
                    if (root16 !== 8'd12) begin bad++; $display("FAIL b2b_root1 got=%0d want=12", root16); end
                end else begin
                    t2 = k;
                    go16 = 1'b0;
                    total++;
                    if (root16 !== 8'd7) begin bad++; $display("FAIL b2b_root2 got=%0d want=7", root16); end
                end
            end
            if (t2 == 0) begin
                @(negedge clk);
                k++;
            end
        end
        go16 = 1'b0;
        total++;
        if (t1 != 9 || t2 != 19) begin
            bad++;
            $display("FAIL b2b_timing t1=%0d t2=%0d want 9/19", t1, t2);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int lat;
        logic b1;
        @(negedge clk);
        @(negedge clk);
        go16 = 1'b1;
        din16 = 16'd200;
        @(negedge clk);
        go16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        total++;
        if (busy16 !== 1'b0 || root16 !== 8'd0) begin
            bad++;
            $display("FAIL midreset busy=%b root=%0d want 0/0", busy16, root16);
        end
        for (int i = 0; i < 14; i++) begin
            if (done16) seen++;
            @(negedge clk);
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL midreset_done pulses=%0d want=0", seen); end
        // reset and go on the same edge: reset wins
        clr_n = 1'b0;
        go16 = 1'b1;
        din16 = 16'd81;
        @(negedge clk);
        go16 = 1'b0;
        clr_n = 1'b1;
        total++;
        if (busy16 !== 1'b0) begin bad++; $display("FAIL reset_vs_go busy=%b want=0", busy16); end
        do_op16(16'd81, lat, b1);
        total++;
        if (root16 !== 8'd9 || lat != 9) begin
            bad++;
            $display("FAIL after_reset_op root=%0d lat=%0d want 9/9", root16, lat);
        end
    endtask

    task automatic test_width8();
        int lat;
        @(negedge clk);
        go8 = 1'b1;
        din8 = 8'd255;
        @(negedge clk);
        go8 = 1'b0;
        din8 = 8'd0;
        lat = 1;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (root8 !== 4'd15 || lat != 5) begin
            bad++;
            $display("FAIL w8 root=%0d lat=%0d want 15/5", root8, lat);
        end
`ifdef SQRT_REM_EN
        total++;
        if (rem8 !== 5'd30) begin bad++; $display("FAIL w8_rem got=%0d want=30", rem8); end
`endif
    endtask

    task automatic test_sweep();
        int lat;
        logic b1;
        logic [15:0] d;
        longint r;
        for (int i = 0; i < 1000; i++) begin
            d = 16'($urandom);
            do_op16(d, lat, b1);
            r = isqrt(longint'(d));
            total++;
            if (longint'(root16) != r) begin
                bad++;
                $display("FAIL sweep_root din=%0d got=%0d want=%0d", d, root16, r);
            end
`ifdef SQRT_REM_EN
            total++;
            if (longint'(rem16) != longint'(d) - r * r) begin
                bad++;
                $display("FAIL sweep_rem din=%0d got=%0d want=%0d", d, rem16, longint'(d) - r * r);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
